// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, the fetch-buffer entry type and a PC alignment helper.
`default_nettype none

package cpu_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; the low address bits are dropped, not trapped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order buffer of {pc, instr} entries with synchronous flush and asynchronous reset.
`default_nettype none

module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head_data,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// instr_fetch: PC register, IMEM request, redirect/flush control and fetch buffer toward decode.
`default_nettype none

module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_pc,
  input  logic [XLEN-1:0] imem_instruction,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            misalign_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [CW-1:0]   fifo_count;
  logic            fetch_en;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  // Fetch is gated on the registered count only: a full buffer never pops-through.
  assign fetch_en = !redirect_valid && (fifo_count < CW'(DEPTH));
  assign pop      = out_valid && out_ready;

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_instruction;

  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (redirect_valid) begin
      pc_d       = align_pc(redirect_pc);
      misalign_d = |redirect_pc[1:0];
    end else if (fetch_en) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fetch_en),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (fifo_count)
  );

  assign imem_pc      = pc_q;
  assign out_valid    = (fifo_count != '0);
  assign out_instr    = head_entry.instr;
  assign out_pc       = head_entry.pc;
  assign misalign_err = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized stimulus with a scoreboard of the expected in-order fetch stream.
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        out_valid;
  logic        out_ready      = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (RST_PC),
    .DEPTH    (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .misalign_err     (misalign_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  assign imem_instruction = mem_word(imem_pc);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] gen_pc;
  int          total    = 0;
  int          bad      = 0;
  int          hs_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // The program as decode should see it: consecutive words from gen_pc onward.
  task automatic refill();
    while (sb_q.size() < 8) begin
      exp_t e;
      e.pc    = gen_pc;
      e.instr = mem_word(gen_pc);
      sb_q.push_back(e);
      gen_pc += 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] start);
    sb_q.delete();
    gen_pc = {start[31:2], 2'b00};
    refill();
  endtask

  // Inputs change at posedge+2; the monitor samples at negedge; the model updates at negedge+1.
  task automatic step(input bit r, input bit rv, input logic [31:0] rpc);
    @(posedge clk);
    #2;
    out_ready      = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    #1;
    if (rv) restart_stream(rpc);
    refill();
  endtask

  // Monitor: stream order, redirect bubble/landing timing and the misalign pulse.
  initial begin
    bit          bub_pend = 0;
    bit          v2_pend  = 0;
    bit          exp_mis  = 0;
    logic [31:0] bub_tgt  = '0;
    logic [31:0] v2_tgt   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bub_pend = 0;
        v2_pend  = 0;
        exp_mis  = 0;
      end else begin
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, exp_mis});
        if (bub_pend) begin
          chk("bubble_valid", {31'd0, out_valid}, 32'd0);
          chk("bubble_imem_pc", imem_pc, bub_tgt);
        end
        if (v2_pend) begin
          chk("landing_valid", {31'd0, out_valid}, 32'd1);
          chk("landing_pc", out_pc, v2_tgt);
        end
        if (out_valid && out_ready) begin
          hs_count++;
          if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_instr", out_instr, e.instr);
          end
        end
        v2_pend  = bub_pend && !redirect_valid;
        v2_tgt   = bub_tgt;
        bub_pend = redirect_valid;
        bub_tgt  = {redirect_pc[31:2], 2'b00};
        exp_mis  = redirect_valid && (redirect_pc[1:0] != 2'b00);
      end
    end
  end

  task automatic release_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    restart_stream(RST_PC);
    #1;
    chk("pre_e0_valid", {31'd0, out_valid}, 32'd0);
    chk("pre_e0_imem_pc", imem_pc, RST_PC);
    @(posedge clk);
    #1;
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_pc", out_pc, RST_PC);
  endtask

  initial begin
    int hs0;
    restart_stream(RST_PC);
    #1;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_imem_pc", imem_pc, RST_PC);
    chk("reset_misalign", {31'd0, misalign_err}, 32'd0);
    repeat (2) @(posedge clk);
    release_reset();

    // Stall: buffer fills to two entries, PC parks two words ahead of the head.
    for (int i = 0; i < 5; i++) step(0, 0, 32'h0);
    chk("stall_imem_pc", imem_pc, 32'h0000_0008);
    chk("stall_out_pc", out_pc, 32'h0000_0000);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);

    // Throughput: one instruction per cycle with ready held high.
    hs0 = hs_count;
    for (int i = 0; i < 12; i++) step(1, 0, 32'h0);
    chk("throughput", hs_count - hs0, 32'd12);

    // Redirect with the buffer full.
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0);
    step(0, 1, 32'h0000_0100);
    for (int i = 0; i < 4; i++) step(1, 0, 32'h0);

    // Misaligned target.
    step(1, 1, 32'h0000_0102);
    for (int i = 0; i < 4; i++) step(1, 0, 32'h0);

    // PC wrap.
    step(1, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 5; i++) step(1, 0, 32'h0);

    // Asynchronous reset mid-stream with two entries buffered.
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_imem_pc", imem_pc, RST_PC);
    chk("async_rst_misalign", {31'd0, misalign_err}, 32'd0);
    release_reset();

    // Randomized traffic.
    hs0 = hs_count;
    for (int i = 0; i < 600; i++) begin
      bit          r;
      bit          rv;
      logic [31:0] t;
      r  = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       t = $urandom();
        1:       t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: t = 32'($urandom_range(0, 255));
      endcase
      step(r, rv, t);
    end
    step(1, 0, 32'h0);
    total++;
    if (hs_count - hs0 < 100) begin
      bad++;
      $display("FAIL random_progress: got %0d handshakes expected at least 100", hs_count - hs0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
